exe_operand_stage: RTL and testbench
====================================

Name: exe_operand_stage

Overview:
- Registered ID/EXE operand stage: selects ALU operands A and B, forwards in-flight results from MEM and WB, and detects load-use hazards.
- Replaces the flat combinational EXE A/B operand muxes with a parametrised stage carrying valid/ready flow control, flush and a stall counter.
- Sits between register-file read (ID) and the ALU (EXE).

Parameters:
- DATA_W, 32, operand/data width.
- ADDR_W, 5, register address width; address 0 is hard-wired zero.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  ID holds a valid instruction.
- in_ready  out  1  stage accepts the ID instruction this cycle.
- rs_addr, rt_addr  in  ADDR_W  source register addresses.
- rs_value, rt_value  in  DATA_W  register-file read data.
- use_rs, use_rt  in  1  instruction reads rs / rt (rt includes store data).
- imm16  in  16  instruction immediate.
- shamt  in  5  shift amount.
- a_sel  in  1  0 = forwarded rs, 1 = zero-extended shamt.
- b_sel  in  2  00 = zero-extended imm16, 01 = sign-extended imm16, 1x = forwarded rt.
- mem_wen, mem_is_load  in  1  MEM-stage write enable; MEM result comes from a load.
- mem_waddr  in  ADDR_W; mem_wdata  in  DATA_W  MEM-stage destination and ALU result.
- wb_wen  in  1; wb_waddr  in  ADDR_W; wb_wdata  in  DATA_W  WB-stage write-back.
- flush  in  1  kill the held instruction and the incoming capture.
- out_valid  out  1; out_ready  in  1  EXE handshake.
- a_out, b_out, rt_fwd_out  out  DATA_W  registered operands; rt_fwd_out is forwarded rt for stores.
- stall_cnt  out  CNT_W  number of cycles in which a load-use hazard was raised.

Behaviour:
- Reset: out_valid, a_out, b_out, rt_fwd_out and stall_cnt are 0. rst has priority over flush and capture.
- Forwarding, per operand (rs, rt), evaluated combinationally:
  - Address 0 always yields 0.
  - Otherwise, if mem_wen and mem_waddr matches and the MEM result is not a load, use mem_wdata.
  - Else, if wb_wen and wb_waddr matches, use wb_wdata.
  - Else use the register-file value.
  - MEM has priority over WB.
- hazard = in_valid & mem_wen & mem_is_load & mem_waddr != 0 & ((use_rs & mem_waddr == rs_addr) | (use_rt & mem_waddr == rt_addr)).
- in_ready = (!out_valid | out_ready) & !hazard & !rst.
- Capture when in_valid & in_ready & !flush:
  - Outputs take the selected operands; out_valid = 1 on the next edge.
  - Latency is 1 cycle.
- Drain: if out_valid & out_ready and there is no capture, out_valid goes to 0.
- Hold: if out_valid & !out_ready, all outputs are held stable and no capture occurs.
- hazard with the stage free: no capture, so out_valid drops to 0 (bubble). The stage releases once MEM no longer holds a matching load; forwarding then comes from WB.
- flush: out_valid = 0 next cycle and the incoming instruction is discarded. Data outputs may hold stale values.
- stall_cnt increments by 1 every cycle hazard = 1. It saturates at all-ones and is not cleared by flush.
- Extensions: zero-extend shamt to DATA_W. imm16 is sign- or zero-extended to DATA_W per b_sel.
- Simultaneous MEM and WB writes to the same address: MEM wins, or the stage stalls if the MEM result is a load.

Decomposition:
- Shared package pipe_pkg holds:
  - A_SEL_RS = 1'b0, A_SEL_SHAMT = 1'b1.
  - B_SEL_ZE16 = 2'b00, B_SEL_SE16 = 2'b01, B_SEL_RT = 2'b1x.
  - Default widths.
- Sub-module fwd_select: combinational per-operand forwarding priority, instantiated twice (rs, rt).

Test Plan:
- Plain capture: rs_value=0x11, rt_value=0x22, a_sel=0, b_sel=2'b10, no forwarding, out_ready=1 -> next cycle out_valid=1, a_out=0x11, b_out=0x22.
- Forward priority: rs_addr=3, mem_wen=1, mem_waddr=3, mem_wdata=0xAAAA, wb_wen=1, wb_waddr=3, wb_wdata=0xBBBB -> a_out=0xAAAA. Repeat with mem_wen=0 -> a_out=0xBBBB. Repeat with rs_addr=0 -> a_out=0.
- Load-use: mem_is_load=1, mem_waddr=5, rt_addr=5, use_rt=1:
  - Cycle 1: in_ready=0, out_valid=0 next, stall_cnt=1.
  - Cycle 2: load moves to WB (wb_wdata=0x1234) -> capture with b_out=0x1234.
- Extensions: imm16=0x8000 with b_sel=01 -> b_out=0xFFFF8000; with b_sel=00 -> b_out=0x00008000. shamt=31 with a_sel=1 -> a_out=31.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then flush=1 with in_valid=1 -> out_valid=0 next cycle, no capture.
- Reset mid-operation: out_valid=1 with stall_cnt=7, assert rst for one cycle -> all outputs 0. Also check stall_cnt saturation with CNT_W=2 (stays 3).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared operand-select encodings and default widths for the ID/EXE operand stage.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic       A_SEL_RS    = 1'b0;
    localparam logic       A_SEL_SHAMT = 1'b1;

    // B_SEL_RT is a wildcard: any b_sel with bit 1 set selects forwarded rt.
    localparam logic [1:0] B_SEL_ZE16  = 2'b00;
    localparam logic [1:0] B_SEL_SE16  = 2'b01;
    localparam logic [1:0] B_SEL_RT    = 2'b1?;

endpackage

// File: rtl/exe_operand_stage_fwd_select.sv
// Per-operand forwarding priority: r0 is zero, then non-load MEM result, then WB, then register file.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rf_value,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] value
);

    // Forwarding priority mux; a matching MEM load is not usable yet, so it falls through.
    always_comb begin
        value = rf_value;
        if (addr == {ADDR_W{1'b0}}) begin
            value = {DATA_W{1'b0}};
        end else if (mem_wen && (mem_waddr == addr) && !mem_is_load) begin
            value = mem_wdata;
        end else if (wb_wen && (wb_waddr == addr)) begin
            value = wb_wdata;
        end else begin
            value = rf_value;
        end
    end

endmodule

// File: rtl/exe_operand_stage.sv
// Registered ID/EXE operand stage: ALU operand selection, MEM/WB forwarding,
// load-use hazard stalling with valid/ready flow control, flush and a saturating stall counter.
module exe_operand_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [15:0]       imm16,
    input  logic [4:0]        shamt,
    input  logic              a_sel,
    input  logic [1:0]        b_sel,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] rt_fwd_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] rs_fwd_s;
    logic [DATA_W-1:0] rt_fwd_s;
    logic [DATA_W-1:0] a_next_s;
    logic [DATA_W-1:0] b_next_s;
    logic              hazard_s;
    logic              capture_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] a_out_r;
    logic [DATA_W-1:0] b_out_r;
    logic [DATA_W-1:0] rt_fwd_out_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
        .addr        (rs_addr),
        .rf_value    (rs_value),
        .mem_wen     (mem_wen),
        .mem_is_load (mem_is_load),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .value       (rs_fwd_s)
    );

    fwd_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
        .addr        (rt_addr),
        .rf_value    (rt_value),
        .mem_wen     (mem_wen),
        .mem_is_load (mem_is_load),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .value       (rt_fwd_s)
    );

    // Load-use hazard detection and handshake qualification.
    always_comb begin
        hazard_s  = in_valid && mem_wen && mem_is_load && (mem_waddr != {ADDR_W{1'b0}}) &&
                    ((use_rs && (mem_waddr == rs_addr)) || (use_rt && (mem_waddr == rt_addr)));
        in_ready  = (!out_valid_r || out_ready) && !hazard_s && !rst;
        capture_s = in_valid && in_ready && !flush;
    end

    // Operand A select: forwarded rs or zero-extended shift amount.
    always_comb begin
        a_next_s = rs_fwd_s;
        case (a_sel)
            A_SEL_RS:    a_next_s = rs_fwd_s;
            A_SEL_SHAMT: a_next_s = {{(DATA_W-5){1'b0}}, shamt};
            default:     a_next_s = rs_fwd_s;
        endcase
    end

    // Operand B select: zero/sign-extended immediate or forwarded rt.
    always_comb begin
        b_next_s = rt_fwd_s;
        casez (b_sel)
            B_SEL_ZE16: b_next_s = {{(DATA_W-16){1'b0}}, imm16};
            B_SEL_SE16: b_next_s = {{(DATA_W-16){imm16[15]}}, imm16};
            B_SEL_RT:   b_next_s = rt_fwd_s;
            default:    b_next_s = rt_fwd_s;
        endcase
    end

    // Output register: capture, drain, flush and hold; flush never touches the stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            a_out_r      <= {DATA_W{1'b0}};
            b_out_r      <= {DATA_W{1'b0}};
            rt_fwd_out_r <= {DATA_W{1'b0}};
            stall_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (hazard_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (capture_s) begin
                out_valid_r  <= 1'b1;
                a_out_r      <= a_next_s;
                b_out_r      <= b_next_s;
                rt_fwd_out_r <= rt_fwd_s;
            end else if (flush || out_ready) begin
                out_valid_r  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign a_out      = a_out_r;
    assign b_out      = b_out_r;
    assign rt_fwd_out = rt_fwd_out_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed self-checking bench for exe_operand_stage, plus a CNT_W=2 instance for counter saturation.
module tb_exe_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_value, rt_value;
    logic        use_rs, use_rt;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic        mem_wen, mem_is_load;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_out, b_out, rt_fwd_out;
    logic [15:0] stall_cnt;

    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_a_out, sat_b_out, sat_rt_fwd_out;
    logic [1:0]  sat_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exe_operand_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_value(rs_value), .rt_value(rt_value),
        .use_rs(use_rs), .use_rt(use_rt), .imm16(imm16), .shamt(shamt),
        .a_sel(a_sel), .b_sel(b_sel), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_wen(wb_wen),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .b_out(b_out),
        .rt_fwd_out(rt_fwd_out), .stall_cnt(stall_cnt)
    );

    exe_operand_stage #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_value(rs_value), .rt_value(rt_value),
        .use_rs(use_rs), .use_rt(use_rt), .imm16(imm16), .shamt(shamt),
        .a_sel(a_sel), .b_sel(b_sel), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_wen(wb_wen),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
        .out_valid(sat_out_valid), .out_ready(out_ready), .a_out(sat_a_out), .b_out(sat_b_out),
        .rt_fwd_out(sat_rt_fwd_out), .stall_cnt(sat_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        rs_value = 32'h0; rt_value = 32'h0; use_rs = 1'b0; use_rt = 1'b0;
        imm16 = 16'h0; shamt = 5'd0; a_sel = 1'b0; b_sel = 2'b00;
        mem_wen = 1'b0; mem_is_load = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0;
        wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_a_out", a_out, 32'd0);
        check("rst_b_out", b_out, 32'd0);
        check("rst_rt_fwd", rt_fwd_out, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Plain capture
        in_valid = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2; rs_value = 32'h11; rt_value = 32'h22;
        use_rs = 1'b1; use_rt = 1'b1; a_sel = 1'b0; b_sel = 2'b10;
        #1 check("plain_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("plain_out_valid", {31'd0, out_valid}, 32'd1);
        check("plain_a_out", a_out, 32'h11);
        check("plain_b_out", b_out, 32'h22);
        check("plain_rt_fwd", rt_fwd_out, 32'h22);

        // Forwarding priority
        rs_addr = 5'd3; mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hAAAA;
        wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hBBBB;
        step();
        check("fwd_mem_a", a_out, 32'hAAAA);
        check("fwd_mem_b_untouched", b_out, 32'h22);
        mem_wen = 1'b0;
        step();
        check("fwd_wb_a", a_out, 32'hBBBB);
        rs_addr = 5'd0; mem_wen = 1'b1;
        step();
        check("fwd_r0_a", a_out, 32'h0);
        mem_wen = 1'b0; wb_wen = 1'b0;

        // Load-use hazard, then release via WB
        rs_addr = 5'd1; rt_addr = 5'd5; rt_value = 32'h99;
        mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hDEAD;
        #1 check("lu_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("lu_out_valid", {31'd0, out_valid}, 32'd0);
        check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        mem_wen = 1'b0; mem_is_load = 1'b0; wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
        #1 check("lu_release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("lu_release_valid", {31'd0, out_valid}, 32'd1);
        check("lu_release_b", b_out, 32'h1234);
        check("lu_release_rt_fwd", rt_fwd_out, 32'h1234);
        check("lu_stall_hold", {16'd0, stall_cnt}, 32'd1);
        wb_wen = 1'b0;

        // Extensions
        imm16 = 16'h8000; b_sel = 2'b01;
        step();
        check("ext_se16", b_out, 32'hFFFF8000);
        b_sel = 2'b00;
        step();
        check("ext_ze16", b_out, 32'h00008000);
        a_sel = 1'b1; shamt = 5'd31;
        step();
        check("ext_shamt", a_out, 32'd31);

        // Backpressure: outputs held, no capture
        out_ready = 1'b0; a_sel = 1'b0; rs_value = 32'h55; b_sel = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_a_out", a_out, 32'd31);
            check("bp_b_out", b_out, 32'h00008000);
        end

        // Flush with an incoming instruction
        out_ready = 1'b1; flush = 1'b1;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("flush_no_capture", {31'd0, out_valid}, 32'd0);

        // Six more hazard cycles: main counter to 7, 2-bit counter saturates at 3
        in_valid = 1'b1; rt_addr = 5'd5; mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd5;
        for (int i = 0; i < 6; i++) step();
        check("sat_stall_main", {16'd0, stall_cnt}, 32'd7);
        check("sat_stall_2bit", {30'd0, sat_stall_cnt}, 32'd3);
        mem_wen = 1'b0; mem_is_load = 1'b0; rt_value = 32'h77;
        step();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_b", b_out, 32'h77);
        check("pre_rst_stall_2bit", {30'd0, sat_stall_cnt}, 32'd3);

        // Reset mid-operation
        rst = 1'b1;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_a", a_out, 32'd0);
        check("midrst_b", b_out, 32'd0);
        check("midrst_rt_fwd", rt_fwd_out, 32'd0);
        check("midrst_stall", {16'd0, stall_cnt}, 32'd0);
        check("midrst_stall_2bit", {30'd0, sat_stall_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
